// File: rtl/reg_file_dbg_arbiter.sv
// Register file port arbiter between CPU writeback and the debug command engine.
// A debug command stalls the front end, drains writebacks, then does one access.
module reg_file_dbg_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_pipe_reg_write,
    input  logic [ADDR_W-1:0] i_pipe_rd,
    input  logic [DATA_W-1:0] i_pipe_wdata,
    input  logic [ADDR_W-1:0] i_pipe_rs1,
    input  logic [ADDR_W-1:0] i_pipe_rs2,
    output logic              o_pipe_stall,
    input  logic              i_dbg_req_valid,
    output logic              o_dbg_req_ready,
    input  logic              i_dbg_req_write,
    input  logic [ADDR_W-1:0] i_dbg_req_addr,
    input  logic [DATA_W-1:0] i_dbg_req_wdata,
    output logic              o_dbg_rsp_valid,
    input  logic              i_dbg_rsp_ready,
    output logic [DATA_W-1:0] o_dbg_rsp_data,
    output logic              o_rf_reg_write,
    output logic [ADDR_W-1:0] o_rf_rd,
    output logic [DATA_W-1:0] o_rf_wdata,
    output logic [ADDR_W-1:0] o_rf_rs1,
    output logic [ADDR_W-1:0] o_rf_rs2,
    input  logic [DATA_W-1:0] i_rf_rdata1
);

    localparam int CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STALL,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_cmd_write;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [DATA_W-1:0] r_cmd_wdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              w_req_fire;
    logic              w_rsp_fire;
    logic [DATA_W-1:0] w_access_data;

    assign w_req_fire = i_dbg_req_valid && o_dbg_req_ready;
    assign w_rsp_fire = (r_state == S_RESP) && r_rsp_valid && i_dbg_rsp_ready;

    // Writes to x0 report the architectural value, not the requested one.
    assign w_access_data = !r_cmd_write ? i_rf_rdata1 :
                           (r_cmd_addr != '0) ? r_cmd_wdata : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_req_fire) begin
                    w_state_nxt = S_STALL;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            S_STALL: begin
                if (r_cnt != '0)
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                if ((r_cnt == '0) && !i_pipe_reg_write)
                    w_state_nxt = S_ACCESS;
            end
            S_ACCESS: w_state_nxt = S_RESP;
            S_RESP: begin
                if (w_rsp_fire)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_pipe_stall    = (r_state == S_STALL) || (r_state == S_ACCESS);
        o_dbg_req_ready = (r_state == S_IDLE) && !i_reset;
        o_rf_reg_write  = i_pipe_reg_write;
        o_rf_rd         = i_pipe_rd;
        o_rf_wdata      = i_pipe_wdata;
        o_rf_rs1        = i_pipe_rs1;
        o_rf_rs2        = i_pipe_rs2;
        if (r_state == S_ACCESS) begin
            o_rf_reg_write = r_cmd_write;
            o_rf_rd        = r_cmd_addr;
            o_rf_wdata     = r_cmd_wdata;
            o_rf_rs1       = r_cmd_addr;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cmd_write <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_req_fire) begin
                r_cmd_write <= i_dbg_req_write;
                r_cmd_addr  <= i_dbg_req_addr;
                r_cmd_wdata <= i_dbg_req_wdata;
            end
            if (r_state == S_ACCESS) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_access_data;
            end else if (w_rsp_fire) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign o_dbg_rsp_valid = r_rsp_valid;
    assign o_dbg_rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_reg_file_dbg_arbiter.sv
// Bench for reg_file_dbg_arbiter: one instance with a 3-cycle drain and one
// with no drain share a behavioural register file; sel picks the active one.
module tb_reg_file_dbg_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rf_clr, sel;
    logic        pw;
    logic [4:0]  prd, prs1, prs2;
    logic [31:0] pwd;
    logic        dv, dw, rr;
    logic [4:0]  da;
    logic [31:0] dwd;
    logic [31:0] rdata1;

    logic        stall3, rdy3, rv3, rfw3;
    logic [31:0] rdat3, rfwd3;
    logic [4:0]  rfrd3, rfrs13, rfrs23;
    logic        stall0, rdy0, rv0, rfw0;
    logic [31:0] rdat0, rfwd0;
    logic [4:0]  rfrd0, rfrs10, rfrs20;

    logic        m_stall, m_rdy, m_rv, m_rfw;
    logic [31:0] m_rdat, m_rfwd;
    logic [4:0]  m_rfrd, m_rfrs1, m_rfrs2;

    logic [31:0] regs [32];
    logic [31:0] exp_regs [32];
    int n_cmp = 0;
    int n_bad = 0;

    reg_file_dbg_arbiter #(.DRAIN_CYCLES(3)) u_dut3 (
        .i_clk(clk), .i_reset(rst),
        .i_pipe_reg_write(pw), .i_pipe_rd(prd), .i_pipe_wdata(pwd),
        .i_pipe_rs1(prs1), .i_pipe_rs2(prs2), .o_pipe_stall(stall3),
        .i_dbg_req_valid(dv & ~sel), .o_dbg_req_ready(rdy3),
        .i_dbg_req_write(dw), .i_dbg_req_addr(da), .i_dbg_req_wdata(dwd),
        .o_dbg_rsp_valid(rv3), .i_dbg_rsp_ready(rr & ~sel),
        .o_dbg_rsp_data(rdat3),
        .o_rf_reg_write(rfw3), .o_rf_rd(rfrd3), .o_rf_wdata(rfwd3),
        .o_rf_rs1(rfrs13), .o_rf_rs2(rfrs23), .i_rf_rdata1(rdata1)
    );

    reg_file_dbg_arbiter #(.DRAIN_CYCLES(0)) u_dut0 (
        .i_clk(clk), .i_reset(rst),
        .i_pipe_reg_write(pw), .i_pipe_rd(prd), .i_pipe_wdata(pwd),
        .i_pipe_rs1(prs1), .i_pipe_rs2(prs2), .o_pipe_stall(stall0),
        .i_dbg_req_valid(dv & sel), .o_dbg_req_ready(rdy0),
        .i_dbg_req_write(dw), .i_dbg_req_addr(da), .i_dbg_req_wdata(dwd),
        .o_dbg_rsp_valid(rv0), .i_dbg_rsp_ready(rr & sel),
        .o_dbg_rsp_data(rdat0),
        .o_rf_reg_write(rfw0), .o_rf_rd(rfrd0), .o_rf_wdata(rfwd0),
        .o_rf_rs1(rfrs10), .o_rf_rs2(rfrs20), .i_rf_rdata1(rdata1)
    );

    assign m_stall = sel ? stall0 : stall3;
    assign m_rdy   = sel ? rdy0   : rdy3;
    assign m_rv    = sel ? rv0    : rv3;
    assign m_rdat  = sel ? rdat0  : rdat3;
    assign m_rfw   = sel ? rfw0   : rfw3;
    assign m_rfrd  = sel ? rfrd0  : rfrd3;
    assign m_rfwd  = sel ? rfwd0  : rfwd3;
    assign m_rfrs1 = sel ? rfrs10 : rfrs13;
    assign m_rfrs2 = sel ? rfrs20 : rfrs23;

    // Register file: x0 reads as zero, writes land on the clock edge
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (m_rfw && m_rfrd != 5'd0) begin
            regs[m_rfrd] <= m_rfwd;
        end
    end
    assign rdata1 = (m_rfrs1 == 5'd0) ? 32'd0 : regs[m_rfrs1];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One debug command; k pipeline writes to krd follow the handshake,
    // the last one carrying kwd. Starts and ends at posedge+1.
    task automatic cmd(input bit w, input logic [4:0] a,
                       input logic [31:0] d, input int k,
                       input logic [4:0] krd, input logic [31:0] kwd,
                       input int hold, input bit pend,
                       output logic [31:0] got);
        int drain, n, nwr, c;
        logic [31:0] ed;
        drain = sel ? 0 : 3;
        dv = 1'b1; dw = w; da = a; dwd = d;
        @(negedge clk);
        check("req_ready_idle", 32'(m_rdy), 32'd1);
        @(posedge clk); #1;
        dv = pend;
        n = 0; nwr = 0; c = 0;
        forever begin
            c++;
            pw  = (c <= k);
            prd = krd;
            pwd = (c == k) ? kwd : $urandom;
            if (pw && krd != 5'd0) exp_regs[krd] = pwd;
            @(negedge clk);
            if (!m_stall || n >= 60) break;
            n++;
            if (m_rfw && !pw) begin
                nwr++;
                check("access_rd", 32'(m_rfrd), 32'(a));
                check("access_wdata", m_rfwd, d);
            end
            if (pend) check("req_ready_busy", 32'(m_rdy), 32'd0);
            @(posedge clk); #1;
        end
        pw = 1'b0;
        check("stall_cycles", n, ((drain > k) ? drain : k) + 2);
        check("access_writes", nwr, w ? 1 : 0);
        if (w) ed = (a != 5'd0) ? d : 32'd0;
        else   ed = exp_regs[a];
        if (w && a != 5'd0) exp_regs[a] = d;
        check("rsp_valid", 32'(m_rv), 32'd1);
        check("rsp_data", m_rdat, ed);
        check("rsp_stall", 32'(m_stall), 32'd0);
        got = m_rdat;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("hold_valid", 32'(m_rv), 32'd1);
            check("hold_data", m_rdat, ed);
            check("hold_stall", 32'(m_stall), 32'd0);
            check("hold_req_ready", 32'(m_rdy), 32'd0);
        end
        @(posedge clk); #1;
        rr = 1'b1;
        @(posedge clk); #1;
        rr = 1'b0;
        dv = 1'b0;
        @(negedge clk);
        check("post_rsp_valid", 32'(m_rv), 32'd0);
        check("post_rsp_ready", 32'(m_rdy), 32'd1);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        pw;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_rfw;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        logic [4:0]  e_rs1;
        logic [4:0]  e_rs2;
    } vec_t;

    initial begin
        vec_t        vt [5];
        logic [31:0] got;
        int          nidle;

        vt[0] = '{1'b0, 5'd1,  32'h0000_0000, 5'd2,  5'd3,
                  1'b0, 5'd1,  32'h0000_0000, 5'd2,  5'd3};
        vt[1] = '{1'b1, 5'd4,  32'h1111_2222, 5'd4,  5'd31,
                  1'b1, 5'd4,  32'h1111_2222, 5'd4,  5'd31};
        vt[2] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 5'd0,  5'd16,
                  1'b1, 5'd31, 32'hFFFF_FFFF, 5'd0,  5'd16};
        vt[3] = '{1'b0, 5'd9,  32'h8000_0001, 5'd31, 5'd0,
                  1'b0, 5'd9,  32'h8000_0001, 5'd31, 5'd0};
        vt[4] = '{1'b1, 5'd6,  32'h0BAD_F00D, 5'd6,  5'd6,
                  1'b1, 5'd6,  32'h0BAD_F00D, 5'd6,  5'd6};

        rst = 1'b1; rf_clr = 1'b1; sel = 1'b0;
        pw = 1'b0; prd = '0; pwd = '0; prs1 = '0; prs2 = '0;
        dv = 1'b0; dw = 1'b0; da = '0; dwd = '0; rr = 1'b0;
        for (int i = 0; i < 32; i++) exp_regs[i] = '0;

        #2;
        check("req_ready_in_reset", 32'(m_rdy), 32'd0);
        check("stall_in_reset", 32'(m_stall), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; rf_clr = 1'b0;
        @(negedge clk);
        check("reset_req_ready", 32'(m_rdy), 32'd1);
        check("reset_stall", 32'(m_stall), 32'd0);
        check("reset_rsp_valid", 32'(m_rv), 32'd0);
        check("reset_rsp_data", m_rdat, 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            pw = vt[i].pw; prd = vt[i].rd; pwd = vt[i].wd;
            prs1 = vt[i].rs1; prs2 = vt[i].rs2;
            if (vt[i].pw && vt[i].rd != 5'd0) exp_regs[vt[i].rd] = vt[i].wd;
            @(negedge clk);
            check("idle_rf_write", 32'(m_rfw), 32'(vt[i].e_rfw));
            check("idle_rf_rd", 32'(m_rfrd), 32'(vt[i].e_rd));
            check("idle_rf_wdata", m_rfwd, vt[i].e_wd);
            check("idle_rf_rs1", 32'(m_rfrs1), 32'(vt[i].e_rs1));
            check("idle_rf_rs2", 32'(m_rfrs2), 32'(vt[i].e_rs2));
            check("idle_stall", 32'(m_stall), 32'd0);
            @(posedge clk); #1;
        end
        pw = 1'b0;

        cmd(1'b1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'd0, 0, 1'b0, got);
        check("write5_rsp", got, 32'hDEAD_BEEF);

        // Asynchronous reset in the middle of a write's drain
        dv = 1'b1; dw = 1'b1; da = 5'd9; dwd = 32'hCAFE_0009;
        @(posedge clk); #1;
        dv = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_reset_stall", 32'(m_stall), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midreset_stall", 32'(m_stall), 32'd0);
        check("midreset_rsp_valid", 32'(m_rv), 32'd0);
        check("midreset_rsp_data", m_rdat, 32'd0);
        check("midreset_req_ready", 32'(m_rdy), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("postreset_req_ready", 32'(m_rdy), 32'd1);
        check("postreset_stall", 32'(m_stall), 32'd0);
        @(posedge clk); #1;
        cmd(1'b0, 5'd9, 32'd0, 0, 5'd0, 32'd0, 0, 1'b0, got);
        check("aborted_write9", got, 32'h8000_0001 & 32'd0);

        cmd(1'b0, 5'd5, 32'd0, 0, 5'd0, 32'd0, 0, 1'b0, got);
        check("read5_rsp", got, 32'hDEAD_BEEF);

        cmd(1'b0, 5'd7, 32'd0, 6, 5'd7, 32'h0000_1234, 0, 1'b0, got);
        check("read7_drain", got, 32'h0000_1234);

        cmd(1'b1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 32'd0, 0, 1'b0, got);
        check("write0_rsp", got, 32'd0);
        cmd(1'b0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 1'b0, got);
        check("read0_rsp", got, 32'd0);

        cmd(1'b1, 5'd12, 32'hA5A5_0012, 0, 5'd0, 32'd0, 10, 1'b1, got);
        check("hold_rsp", got, 32'hA5A5_0012);

        sel = 1'b1;
        cmd(1'b1, 5'd3, 32'h3333_0003, 0, 5'd0, 32'd0, 0, 1'b0, got);
        check("nodrain_write", got, 32'h3333_0003);
        cmd(1'b0, 5'd3, 32'd0, 0, 5'd0, 32'd0, 0, 1'b0, got);
        check("nodrain_read", got, 32'h3333_0003);

        for (int t = 0; t < 30; t++) begin
            sel = 1'($urandom_range(0, 1));
            nidle = $urandom_range(0, 3);
            for (int j = 0; j < nidle; j++) begin
                pw = 1'($urandom_range(0, 1));
                prd = 5'($urandom_range(0, 7));
                pwd = $urandom;
                prs1 = 5'($urandom_range(0, 31));
                prs2 = 5'($urandom_range(0, 31));
                if (pw && prd != 5'd0) exp_regs[prd] = pwd;
                @(negedge clk);
                check("rand_idle_rd", 32'(m_rfrd), 32'(prd));
                check("rand_idle_rs1", 32'(m_rfrs1), 32'(prs1));
                @(posedge clk); #1;
            end
            pw = 1'b0;
            cmd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 5), 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 3), 1'($urandom_range(0, 1)), got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
